// File: rtl/perf_monitor.sv
// Pipeline performance monitor: counts cycles, load-use stalls, flushes and retired
// instructions while enabled, with an optional cycle limit and a registered read port.
module perf_monitor #(
    parameter int unsigned CNT_W            = 32,
    parameter bit          SKIP_FIRST_STALL = 1'b1
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             start_i,
    input  logic             stall_i,
    input  logic             flush_i,
    input  logic             retire_i,
    input  logic [CNT_W-1:0] limit_i,
    input  logic             rd_req_i,
    input  logic [1:0]       rd_addr_i,
    output logic             rd_valid_o,
    output logic [CNT_W-1:0] rd_data_o,
    output logic             done_o
);

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StDone
    } state_e;

    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    state_e           r_state;
    state_e           w_state_d;
    logic [CNT_W-1:0] r_cycles;
    logic [CNT_W-1:0] r_stalls;
    logic [CNT_W-1:0] r_flushes;
    logic [CNT_W-1:0] r_retired;
    logic             r_skip;
    logic             r_rd_valid;
    logic [CNT_W-1:0] r_rd_data;
    logic             w_count;
    logic             w_limit_hit;
    logic [CNT_W-1:0] w_rd_sel;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == CNT_MAX) ? v : v + CNT_ONE;
    endfunction

    assign w_count     = (r_state == StRun) && start_i;
    assign w_limit_hit = w_count && (limit_i != '0) && (r_cycles == limit_i - CNT_ONE);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_d;
        end
    end

    always_comb begin
        w_state_d = r_state;
        unique case (r_state)
            StIdle:  if (start_i) w_state_d = StRun;
            StRun:   if (w_limit_hit) w_state_d = StDone;
            StDone:  w_state_d = StDone;
            default: w_state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_cycles  <= '0;
            r_stalls  <= '0;
            r_flushes <= '0;
            r_retired <= '0;
            r_skip    <= SKIP_FIRST_STALL;
        end else if (w_count) begin
            r_cycles <= sat_inc(r_cycles);
            if (flush_i)  r_flushes <= sat_inc(r_flushes);
            if (retire_i) r_retired <= sat_inc(r_retired);
            // The first eligible stall only consumes the skip flag.
            if (stall_i) begin
                if (r_skip) begin
                    r_skip <= 1'b0;
                end else begin
                    r_stalls <= sat_inc(r_stalls);
                end
            end
        end
    end

    always_comb begin
        w_rd_sel = '0;
        unique case (rd_addr_i)
            2'd0:    w_rd_sel = r_cycles;
            2'd1:    w_rd_sel = r_stalls;
            2'd2:    w_rd_sel = r_flushes;
            2'd3:    w_rd_sel = r_retired;
            default: w_rd_sel = '0;
        endcase
    end

    // Read data is the pre-update counter value, zeroed when no read is returning.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_rd_valid <= 1'b0;
            r_rd_data  <= '0;
        end else begin
            r_rd_valid <= rd_req_i;
            r_rd_data  <= rd_req_i ? w_rd_sel : '0;
        end
    end

    assign rd_valid_o = r_rd_valid;
    assign rd_data_o  = r_rd_data;
    assign done_o     = (r_state == StDone);

endmodule

// File: tb/tb_perf_monitor.sv
// Directed bench for perf_monitor: a default instance and a 4-bit, no-skip instance
// driven by the same stimulus and checked against hand-computed values.
module tb_perf_monitor;

    logic        clk;
    logic        rst;
    logic        start;
    logic        stall;
    logic        flush;
    logic        retire;
    logic [31:0] limit;
    logic [3:0]  limit4;
    logic        rd_req;
    logic [1:0]  rd_addr;
    logic        rd_valid;
    logic [31:0] rd_data;
    logic        done;
    logic        rd_valid4;
    logic [3:0]  rd_data4;
    logic        done4;

    int n_pass  = 0;
    int n_total = 0;

    perf_monitor dut (
        .clk_i     (clk),
        .rst_i     (rst),
        .start_i   (start),
        .stall_i   (stall),
        .flush_i   (flush),
        .retire_i  (retire),
        .limit_i   (limit),
        .rd_req_i  (rd_req),
        .rd_addr_i (rd_addr),
        .rd_valid_o(rd_valid),
        .rd_data_o (rd_data),
        .done_o    (done)
    );

    perf_monitor #(
        .CNT_W           (4),
        .SKIP_FIRST_STALL(1'b0)
    ) dut4 (
        .clk_i     (clk),
        .rst_i     (rst),
        .start_i   (start),
        .stall_i   (stall),
        .flush_i   (flush),
        .retire_i  (retire),
        .limit_i   (limit4),
        .rd_req_i  (rd_req),
        .rd_addr_i (rd_addr),
        .rd_valid_o(rd_valid4),
        .rd_data_o (rd_data4),
        .done_o    (done4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        start;
        logic        stall;
        logic        flush;
        logic        retire;
        logic        rd_req;
        logic [1:0]  addr;
        logic        exp_valid;
        logic [31:0] exp_data;
        logic [3:0]  exp_data4;
    } vec_t;

    vec_t vecs[10];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    endtask

    task automatic set_in(input logic s, input logic st, input logic fl, input logic rt,
                          input logic rq, input logic [1:0] ad);
        start   = s;
        stall   = st;
        flush   = fl;
        retire  = rt;
        rd_req  = rq;
        rd_addr = ad;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        set_in(0, 0, 0, 0, 0, 2'd0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    logic [31:0] exp_main[4];
    logic [31:0] exp_four[4];

    initial begin
        rst    = 1'b1;
        limit  = '0;
        limit4 = '0;
        set_in(0, 0, 0, 0, 0, 2'd0);
        #1;
        check("reset valid", {31'd0, rd_valid}, 32'd0);
        check("reset data", rd_data, 32'd0);
        check("reset done", {31'd0, done}, 32'd0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        // start stall flush retire rd_req addr | valid data data4
        vecs[0] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 2'd0, 1'b1, 32'd0, 4'd0};
        vecs[1] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 32'd0, 4'd0};
        vecs[2] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 2'd1, 1'b1, 32'd0, 4'd1};
        vecs[3] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 2'd1, 1'b1, 32'd1, 4'd2};
        vecs[4] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 2'd0, 1'b1, 32'd3, 4'd3};
        vecs[5] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 2'd2, 1'b1, 32'd1, 4'd1};
        vecs[6] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 2'd3, 1'b1, 32'd1, 4'd1};
        vecs[7] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 2'd0, 1'b1, 32'd4, 4'd4};
        vecs[8] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 32'd0, 4'd0};
        vecs[9] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'd0, 1'b1, 32'd5, 4'd5};

        for (int i = 0; i < 10; i++) begin
            set_in(vecs[i].start, vecs[i].stall, vecs[i].flush, vecs[i].retire,
                   vecs[i].rd_req, vecs[i].addr);
            step();
            check($sformatf("vec%0d valid", i), {31'd0, rd_valid}, {31'd0, vecs[i].exp_valid});
            check($sformatf("vec%0d data", i), rd_data, vecs[i].exp_data);
            check($sformatf("vec%0d data4", i), {28'd0, rd_data4}, {28'd0, vecs[i].exp_data4});
        end

        // Stall skip, pause with events, back-to-back reads.
        do_reset();
        set_in(1, 0, 0, 0, 0, 2'd0);
        step();
        for (int i = 0; i < 3; i++) begin set_in(1, 1, 1, 1, 0, 2'd0); step(); end
        for (int i = 0; i < 4; i++) begin set_in(0, 1, 1, 1, 0, 2'd0); step(); end
        for (int i = 0; i < 2; i++) begin set_in(1, 0, 1, 1, 0, 2'd0); step(); end
        exp_main = '{32'd5, 32'd2, 32'd5, 32'd5};
        exp_four = '{32'd5, 32'd3, 32'd5, 32'd5};
        for (int a = 0; a < 4; a++) begin
            set_in(0, 0, 0, 0, 1, 2'(a));
            step();
            check($sformatf("b2b valid a%0d", a), {31'd0, rd_valid}, 32'd1);
            check($sformatf("b2b data a%0d", a), rd_data, exp_main[a]);
            check($sformatf("b2b data4 a%0d", a), {28'd0, rd_data4}, exp_four[a]);
        end
        set_in(0, 0, 0, 0, 0, 2'd0);
        step();
        check("idle read valid", {31'd0, rd_valid}, 32'd0);
        check("idle read data", rd_data, 32'd0);

        // Asynchronous reset while a read result is on the outputs and another is requested.
        set_in(1, 0, 0, 0, 1, 2'd0);
        step();
        check("pre-rst valid", {31'd0, rd_valid}, 32'd1);
        check("pre-rst data", rd_data, 32'd5);
        #2 rst = 1'b1;
        #1;
        check("async rst valid", {31'd0, rd_valid}, 32'd0);
        check("async rst data", rd_data, 32'd0);
        check("async rst done", {31'd0, done}, 32'd0);
        @(posedge clk);
        #1 rst = 1'b0;
        set_in(0, 0, 0, 0, 0, 2'd0);
        step();
        check("post-rst no valid", {31'd0, rd_valid}, 32'd0);
        for (int a = 0; a < 4; a++) begin
            set_in(0, 0, 0, 0, 1, 2'(a));
            step();
            check($sformatf("post-rst cnt a%0d", a), rd_data, 32'd0);
        end
        // IDLE -> RUN edge must not count; second read shows cycles still 0.
        set_in(1, 0, 0, 0, 1, 2'd0);
        step();
        set_in(0, 0, 0, 0, 1, 2'd0);
        step();
        check("post-rst idle start", rd_data, 32'd0);

        // Limit 100 run; default instance stops, 4-bit instance saturates.
        do_reset();
        limit = 32'd100;
        set_in(1, 0, 0, 0, 0, 2'd0);
        step();
        for (int k = 1; k <= 100; k++) begin
            set_in(1, 0, 0, 0, (k == 8), 2'd0);
            step();
            if (k == 8) begin
                check("read at 7 valid", {31'd0, rd_valid}, 32'd1);
                check("read at 7 data", rd_data, 32'd7);
            end
            if (k == 99) check("done before limit", {31'd0, done}, 32'd0);
            if (k == 100) check("done at limit", {31'd0, done}, 32'd1);
        end
        set_in(1, 1, 1, 1, 0, 2'd0);
        step();
        set_in(1, 1, 1, 1, 1, 2'd0);
        step();
        check("frozen cycles", rd_data, 32'd100);
        check("sat cycles4", {28'd0, rd_data4}, 32'd15);
        check("done4 low", {31'd0, done4}, 32'd0);
        set_in(0, 0, 0, 0, 1, 2'd1);
        step();
        check("done stalls ignored", rd_data, 32'd0);
        check("done held", {31'd0, done}, 32'd1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/perf_monitor.md
PERF_MONITOR -- requirements
Module: perf_monitor

Interface
REQ-001 Parameter CNT_W, default 32, width of every event counter and of rd_data_o.
REQ-002 Parameter SKIP_FIRST_STALL, default 1, when 1 the first stall event after reset is not counted.
REQ-003 clk_i  input  1  single clock; all state updates on rising edge.
REQ-004 rst_i  input  1  reset, asynchronous and active-high.
REQ-005 start_i  input  1  run enable from the CPU top; counting only while high.
REQ-006 stall_i  input  1  load-use stall event from hazard detection, one per cycle max.
REQ-007 flush_i  input  1  IF/ID flush event from branch resolution.
REQ-008 retire_i  input  1  valid instruction leaving WB this cycle.
REQ-009 limit_i  input  CNT_W  cycle limit; 0 means unlimited.
REQ-010 rd_req_i  input  1  counter read request.
REQ-011 rd_addr_i  input  2  counter select: 0 cycles, 1 stalls, 2 flushes, 3 retired.
REQ-012 rd_valid_o  output  1  read data valid, one-cycle pulse.
REQ-013 rd_data_o  output  CNT_W  read data.
REQ-014 done_o  output  1  limit reached; counters frozen.

Function
REQ-015 FSM states IDLE, RUN, DONE; IDLE after reset.
REQ-016 IDLE -> RUN on a rising edge with start_i=1; no counter updates on that edge.
REQ-017 In RUN, each edge with start_i=1: cycle counter +1; stall/flush/retired counters +1 each if their input is 1.
REQ-018 In RUN with start_i=0: all counters hold, state stays RUN (pause, not exit).
REQ-019 RUN -> DONE on the counting edge where cycle counter goes from limit_i-1 to limit_i (limit_i != 0); events on that edge are counted.
REQ-020 limit_i=0: never enters DONE.
REQ-021 DONE is terminal until reset; no counter changes; done_o = 1 while state is DONE (registered, asserted the cycle after the final counting edge).
REQ-022 Stall skip: with SKIP_FIRST_STALL=1, a one-bit skip flag set at reset discards the first counted-eligible stall_i and clears; subsequent stalls count. With 0, all stalls count.
REQ-023 All counters saturate at all-ones; no wrap.
REQ-024 Read: rd_req_i sampled on rising edge in any state; next cycle rd_valid_o=1 and rd_data_o = selected counter value as held before that edge's update.
REQ-025 Back-to-back reads every cycle supported; each produces its own one-cycle rd_valid_o pulse.
REQ-026 rd_data_o = 0 whenever rd_valid_o = 0.
REQ-027 Events in IDLE or DONE are ignored, including for the stall skip flag.

Reset
REQ-028 rst_i=1 asynchronously forces: state IDLE, all counters 0, skip flag set, rd_valid_o=0, rd_data_o=0, done_o=0.
REQ-029 Reset mid-RUN or mid-read discards the pending read; no rd_valid_o pulse after reset release.
REQ-030 After reset release the block behaves exactly as after power-up.

Verification
REQ-031 limit_i=100, start_i held 1, no events -> done_o rises one cycle after cycle counter reaches 100; cycles read = 100.
REQ-032 SKIP_FIRST_STALL=1, stall_i pulsed on 3 RUN cycles -> stall counter read = 2; with parameter 0 -> 3.
REQ-033 flush_i and retire_i high on same 5 RUN cycles, start_i low 4 cycles in between -> flushes=5, retired=5, cycle count excludes the 4 paused cycles.
REQ-034 rd_req_i with rd_addr_i=0 on an edge where cycle counter is 7 and counting -> next cycle rd_valid_o=1, rd_data_o=7.
REQ-035 CNT_W=4, limit_i=0, run 20 cycles -> cycles read = 15 (saturated), done_o stays 0.
REQ-036 rst_i pulsed asynchronously mid-RUN with a read pending -> outputs 0 immediately, no rd_valid_o afterwards, state IDLE, all counters read 0.
